// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register scoreboard and issue-stall controller for the 15-entry register
//   file of the 5-stage pipeline. For each architectural register it counts
//   the issued instructions that still have a write outstanding. It stalls ID
//   on read-after-write hazards against those registers and retires pending
//   writes as the WB-stage write port fires.
//
//   Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a consumer issue
//   in the same cycle as the final outstanding write-back to its source. This
//   needs a WB->ID forwarding path or a write-through register file.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   issue_valid           ID holds an instruction requesting issue
//   src1/src2(_valid)     ID source indices and their read enables
//   issue_wb_en/dest      ID instruction writes register issue_dest
//   flush                 kill the ID instruction (suppresses issue)
//   writeBackEn/Dest_wb   WB-stage register file write
//   stall                 combinational: freeze IF/ID
//   issue_accept          combinational: ID instruction advances
//   pending               registered: bit r set while cnt[r] != 0
//   busy                  OR of pending
//   err                   sticky write-back underflow flag
module regfile_scoreboard #(
    parameter int NUM_REGS = 15,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    src1,
    input  logic [IDX_W-1:0]    src2,
    input  logic                src1_valid,
    input  logic                src2_valid,
    input  logic                issue_wb_en,
    input  logic [IDX_W-1:0]    issue_dest,
    input  logic                flush,
    input  logic                writeBackEn,
    input  logic [IDX_W-1:0]    Dest_wb,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] pending,
    output logic                busy,
    output logic                err
);

    localparam logic [IDX_W:0]   LP_NREGS = (IDX_W+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_err;

    // Counter lookups; untracked indices (>= NUM_REGS) read as zero, which
    // makes them hazard-free and never saturated without extra range checks.
    logic [CNT_W-1:0]    w_c1, w_c2, w_cd, w_cw;
    logic                w_wb_in_range;
    logic                w_haz1, w_haz2, w_sat;
    logic                w_underflow;
    logic [NUM_REGS-1:0] w_inc, w_dec;

    always_comb begin
        w_c1 = '0;
        w_c2 = '0;
        w_cd = '0;
        w_cw = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (src1       == r[IDX_W-1:0]) w_c1 = r_cnt[r];
            if (src2       == r[IDX_W-1:0]) w_c2 = r_cnt[r];
            if (issue_dest == r[IDX_W-1:0]) w_cd = r_cnt[r];
            if (Dest_wb    == r[IDX_W-1:0]) w_cw = r_cnt[r];
        end
    end

    assign w_wb_in_range = ({1'b0, Dest_wb} < LP_NREGS);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write lands this cycle and is forwarded to ID.
    assign w_haz1 = src1_valid && (w_c1 != '0) &&
                    !(writeBackEn && (Dest_wb == src1) && (w_c1 == LP_ONE));
    assign w_haz2 = src2_valid && (w_c2 != '0) &&
                    !(writeBackEn && (Dest_wb == src2) && (w_c2 == LP_ONE));
`else
    assign w_haz1 = src1_valid && (w_c1 != '0);
    assign w_haz2 = src2_valid && (w_c2 != '0);
`endif

    assign w_sat        = issue_wb_en && (w_cd == '1);
    assign stall        = issue_valid && !flush && (w_haz1 || w_haz2 || w_sat);
    assign issue_accept = issue_valid && !flush && !stall;
    assign w_underflow  = writeBackEn && w_wb_in_range && (w_cw == '0);

    always_comb begin
        w_inc   = '0;
        w_dec   = '0;
        pending = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_inc[r]   = issue_accept && issue_wb_en && (issue_dest == r[IDX_W-1:0]);
            w_dec[r]   = writeBackEn && (Dest_wb == r[IDX_W-1:0]) && (r_cnt[r] != '0);
            pending[r] = (r_cnt[r] != '0);
        end
    end

    assign busy = |pending;
    assign err  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + LP_ONE;
                end else if (w_dec[r] && !w_inc[r]) begin
                    r_cnt[r] <= r_cnt[r] - LP_ONE;
                end
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver applies one directed vector per cycle and
// pushes the hand-computed expected outputs; a monitor pops and compares.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  src1, src2;
    logic        src1_valid, src2_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic        flush;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic        stall, issue_accept, busy, err;
    logic [14:0] pending;

    typedef struct packed {
        int          id;
        logic        stall;
        logic        acc;
        logic [14:0] pend;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.NUM_REGS(15), .IDX_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .src1(src1), .src2(src2),
        .src1_valid(src1_valid), .src2_valid(src2_valid),
        .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .flush(flush),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
        .stall(stall), .issue_accept(issue_accept),
        .pending(pending), .busy(busy), .err(err)
    );

    // Monitor: the DUT presents a response every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (stall !== e.stall) begin
                    failures++;
                    $display("FAIL step%0d stall: got %b want %b", e.id, stall, e.stall);
                end
                checks++;
                if (issue_accept !== e.acc) begin
                    failures++;
                    $display("FAIL step%0d issue_accept: got %b want %b", e.id, issue_accept, e.acc);
                end
                checks++;
                if (pending !== e.pend) begin
                    failures++;
                    $display("FAIL step%0d pending: got %h want %h", e.id, pending, e.pend);
                end
                checks++;
                if (busy !== (|e.pend)) begin
                    failures++;
                    $display("FAIL step%0d busy: got %b want %b", e.id, busy, |e.pend);
                end
                checks++;
                if (err !== e.err) begin
                    failures++;
                    $display("FAIL step%0d err: got %b want %b", e.id, err, e.err);
                end
            end
        end
    end

    task automatic step(input logic iv, input logic [3:0] s1, input logic s1v,
                        input logic [3:0] s2, input logic s2v,
                        input logic wben, input logic [3:0] dest, input logic fl,
                        input logic wb, input logic [3:0] dwb,
                        input logic e_stall, input logic e_acc,
                        input logic [14:0] e_pend, input logic e_err);
        exp_t e;
        @(negedge clk);
        issue_valid = iv;  src1 = s1;  src1_valid = s1v;
        src2 = s2;  src2_valid = s2v;
        issue_wb_en = wben;  issue_dest = dest;  flush = fl;
        writeBackEn = wb;  Dest_wb = dwb;
        e.id = step_id;  e.stall = e_stall;  e.acc = e_acc;
        e.pend = e_pend; e.err = e_err;
        q.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [14:0] e_pend, input logic e_err);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pend, e_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 0; src1 = 0; src2 = 0; src1_valid = 0; src2_valid = 0;
        issue_wb_en = 0; issue_dest = 0; flush = 0; writeBackEn = 0; Dest_wb = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // iv s1 s1v s2 s2v wben dest fl wb dwb | stall acc pend err
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 15'h0000, 0); // reset state
        // RAW on r2
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 1, 15'h0000, 0);
        step(1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 15'h0004, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        step(1, 2, 1, 0, 0, 0, 0, 0, 1, 2,  0, 1, 15'h0004, 0);
`else
        step(1, 2, 1, 0, 0, 0, 0, 0, 1, 2,  1, 0, 15'h0004, 0);
`endif
        step(1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 15'h0000, 0);
        // same-cycle inc and dec on r5
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 1, 15'h0000, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 1, 5,  0, 1, 15'h0020, 0);
        idle(15'h0020, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 15'h0020, 0);
        idle(15'h0000, 0);
        // saturation on r7
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 1, 15'h0000, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 1, 15'h0080, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 1, 15'h0080, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  1, 0, 15'h0080, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 1, 7,  1, 0, 15'h0080, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 1, 15'h0080, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 15'h0080, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 15'h0080, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 15'h0080, 0);
        idle(15'h0000, 0);
        // src2 hazard, src_valid gating, flush priority on r4
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0,  0, 1, 15'h0000, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 15'h0010, 0);
        step(1, 0, 0, 4, 0, 0, 0, 0, 0, 0,  0, 1, 15'h0010, 0);
        step(1, 0, 0, 4, 1, 1, 4, 1, 0, 0,  0, 0, 15'h0010, 0);
        step(1, 0, 0, 0, 0, 1, 4, 1, 1, 4,  0, 0, 15'h0010, 0);
        idle(15'h0000, 0);
        // untracked index 15
        step(1, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0, 1, 15'h0000, 0);
        idle(15'h0000, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 15'h0000, 0);
        idle(15'h0000, 0);
        // underflow on r9, sticky
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 15'h0000, 0);
        for (int i = 0; i < 11; i++) idle(15'h0000, 1);
        do_reset();
        idle(15'h0000, 0);
        // reset discards pending writes; the late write-back underflows
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 1, 15'h0000, 0);
        idle(15'h0008, 0);
        do_reset();
        idle(15'h0000, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 0, 15'h0000, 0);
        idle(15'h0000, 1);

        // let the monitor drain, bounded
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
